// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Holds op encodings, FSM states and the fixed datapath width.
package muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int ITERS  = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between control, register file and muldiv_unit.
// Master drives operands and commands; slave returns status and HI/LO.
interface muldiv_if;
    import muldiv_pkg::*;

    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              hi_write;
    logic              lo_write;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_write, lo_write,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_write, lo_write,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply or
// restoring trial-subtract divide on unsigned magnitudes.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic                is_div,
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W-1:0]   rem,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] acc_nxt,
    output logic [DATA_W-1:0]   rem_nxt
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   sh;
    logic [DATA_W-1:0] diff;
    logic              fits;

    always_comb begin
        sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, b};
        sh      = {rem, acc[DATA_W-1]};
        fits    = (sh >= {1'b0, b});
        // result is below divisor when it fits, so 32 bits suffice
        diff    = sh[DATA_W-1:0] - b;
        acc_nxt = acc;
        rem_nxt = rem;
        if (is_div) begin
            acc_nxt = {{DATA_W{1'b0}}, acc[DATA_W-2:0], fits};
            rem_nxt = fits ? diff : sh[DATA_W-1:0];
        end else if (acc[0]) begin
            acc_nxt = {sum, acc[DATA_W-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[2*DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One result bit per clock; sign fix-up in a final FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_t              state, state_nxt;
    logic [4:0]          cnt;
    logic [2*DATA_W-1:0] acc, acc_nxt;
    logic [DATA_W-1:0]   rem, rem_nxt;
    logic [DATA_W-1:0]   b;
    logic [DATA_W-1:0]   rs_keep;
    logic                is_div;
    logic                neg_q;
    logic                neg_r;
    logic                div0;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                done_q;

    logic                sgn;
    logic [DATA_W-1:0]   ma, mb;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rmd;

    muldiv_step u_step (
        .is_div  (is_div),
        .acc     (acc),
        .rem     (rem),
        .b       (b),
        .acc_nxt (acc_nxt),
        .rem_nxt (rem_nxt)
    );

    always_comb begin
        sgn  = ~bus.op[0];
        ma   = (sgn && bus.rs_data[DATA_W-1]) ? -bus.rs_data : bus.rs_data;
        mb   = (sgn && bus.rt_data[DATA_W-1]) ? -bus.rt_data : bus.rt_data;
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        rmd  = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = CALC;
            CALC: if (cnt == 5'(ITERS - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            b       <= '0;
            rs_keep <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div  <= bus.op[1];
                        acc     <= {{DATA_W{1'b0}}, bus.op[1] ? ma : mb};
                        b       <= bus.op[1] ? mb : ma;
                        rem     <= '0;
                        cnt     <= '0;
                        rs_keep <= bus.rs_data;
                        neg_q   <= sgn & (bus.rs_data[DATA_W-1] ^ bus.rt_data[DATA_W-1]);
                        neg_r   <= sgn & bus.rs_data[DATA_W-1];
                        div0    <= bus.op[1] & (bus.rt_data == '0);
                    end else begin
                        if (bus.hi_write) hi_q <= bus.rs_data;
                        if (bus.lo_write) lo_q <= bus.rs_data;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    done_q <= 1'b1;
                    // divide by zero reports the raw dividend, never a signed fix-up
                    if (div0) begin
                        hi_q <= rs_keep;
                        lo_q <= '1;
                    end else if (is_div) begin
                        hi_q <= rmd;
                        lo_q <= quo;
                    end else begin
                        hi_q <= prod[2*DATA_W-1:DATA_W];
                        lo_q <= prod[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file: it consumes the two read ports (rs on port 1, rt on port 2) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the architectural HI/LO registers. It computes one result bit per clock with a shift-add multiplier and a restoring divider, and signals busy/done so the control unit can stall MFHI/MFLO and any new mult/div issue.

## Interface
Parameters:
- none; width fixed at 32, iteration count 32 (package constants).

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  launch operation `op` this cycle; only honoured in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  32  multiplicand / dividend; also MTHI/MTLO data
- rt_data  in  32  multiplier / divisor
- hi_write  in  1  MTHI: HI <= rs_data
- lo_write  in  1  MTLO: LO <= rs_data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, HI/LO hold new result
- hi  out  32  HI register (MFHI source)
- lo  out  32  LO register (MFLO source)

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start: latch operands, convert to magnitudes for signed ops (MULT/DIV), record result signs; counter <= 0; -> CALC.
- CALC, multiply: 64-bit accumulator {HI':LO'}; if LSB of multiplier set, add multiplicand into upper 33 bits; shift right 1.
- CALC, divide: 33-bit partial remainder; shift in next dividend bit, trial subtract divisor, quotient bit = no-borrow, restore on borrow.
- Counter 0..31; after iteration with counter 31 -> FIX.
- FIX: apply signs (product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign); write HI (product[63:32] / remainder), LO (product[31:0] / quotient); done <= 1; -> IDLE.
- Divide by zero: LO = 0xFFFFFFFF, HI = rs_data (signed and unsigned alike; no trap).
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (falls out of magnitude arithmetic).
- start while busy: ignored, no effect on running op.
- hi_write/lo_write: honoured only in IDLE with start low; ignored when busy or when start is high in the same cycle (start wins).
- hi_write and lo_write together in IDLE: both registers load rs_data.

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0.
- Reset mid-operation: next cycle IDLE, busy 0, done 0, HI/LO cleared; partial result discarded.
- Start sampled at edge E0: busy = 1 from after E0 until after E33 (33 cycles).
- Iterations at edges E1..E32; FIX at E33 writes HI/LO; done = 1 for exactly the cycle after E33; busy = 0 in that same cycle.
- Back-to-back: start may be asserted in the done cycle; it is accepted (state is IDLE).
- MTHI/MTLO at edge E: hi/lo show new value after E (1-cycle latency).
- hi/lo are registered outputs; stable throughout CALC (old values until FIX).

## Structure
- Package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (IDLE, CALC, FIX), constants DATA_W = 32, ITERS = 32.
- One sub-module natural: muldiv_step, combinational single-iteration datapath (multiply add-shift / divide trial-subtract) selected by op class; FSM, counter, sign handling and HI/LO stay in muldiv_unit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles done pulse, HI = 0xFFFFFFFE, LO = 0x00000001; busy high exactly 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; DIV 0xFFFFFFF9 (−7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 10 / 0 -> LO = 0xFFFFFFFF, HI = 0x0000000A; DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Start MULTU 3×5, pulse start with DIVU 100/7 at cycle 10 and hi_write at cycle 12 -> both ignored; result HI = 0, LO = 15.
- Start DIVU 100/7, reset at cycle 20 -> next cycle busy 0, HI = LO = 0, no done pulse; new DIVU 100/7 -> LO = 14, HI = 2.
- IDLE: MTLO 0x12345678 then start in done cycle of a prior op -> LO visible next cycle; back-to-back op accepted with no idle gap.
